fifo_protocol_monitor: RTL and testbench

Synthesizable, parametrised protocol checker and reference model for valid/ready FIFOs. It sits passively beside any FIFO instance in the design.
- Keeps a shadow occupancy count and a shadow data queue.
- Checks the DUT's count, ordering, overflow/underflow, output stability and output stall.
- Reports violations as registered sticky error flags plus occupancy statistics.
- Supersedes the count-only property checker: adds data checking, a bypass mode, stall timeout and a high watermark.

---
 rtl/fifo_protocol_monitor.sv | 109 ++++++++++
 tb/tb_fifo_protocol_monitor.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fifo_protocol_monitor.sv
// Passive valid/ready FIFO checker: shadow occupancy and data queue, sticky
// protocol error flags, and an occupancy high watermark.
module fifo_protocol_monitor #(
  parameter int DEPTH       = 16,
  parameter int WIDTH       = 8,
  parameter int STALL_MAX   = 64,
  parameter int CHECK_DATA  = 1,
  parameter int FULL_BYPASS = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         out_valid,
  input  logic                         out_ready,
  input  logic [WIDTH-1:0]             out_data,
  input  logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic                         clear,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic                         err_count,
  output logic                         err_data,
  output logic                         err_stability,
  output logic                         err_stall,
  output logic                         err_any,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic [$clog2(DEPTH+1)-1:0]   max_occ
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STALL_MAX+1);

  logic          push, pop, full, empty, stall, wr_en, rd_en;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ_nxt, max_nxt;
  logic [SW-1:0] stall_cnt, stall_nxt;
  logic          stalled_q;
  logic [WIDTH-1:0] hold_data;
  logic          ovf_bad, unf_bad, cnt_bad, data_bad, stab_bad, stall_bad;
  logic [5:0]    err_q, det;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  assign full  = (occ == CW'(DEPTH));
  assign empty = (occ == '0);
  assign stall = out_valid && !out_ready;

  // A pop with nothing stored is underflow and never consumes an entry; a
  // push at full is only taken when a real pop frees the slot that cycle.
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign occ_nxt = occ + CW'(wr_en) - CW'(rd_en);
  assign max_nxt = clear ? occ_nxt : ((occ_nxt > max_occ) ? occ_nxt : max_occ);

  assign stall_nxt = !stall ? '0 :
                     (stall_cnt == SW'(STALL_MAX)) ? stall_cnt : stall_cnt + 1'b1;

  assign ovf_bad   = full && in_ready && ((FULL_BYPASS == 0) || !pop);
  assign unf_bad   = empty && out_valid;
  assign cnt_bad   = (count != occ) || (count > CW'(DEPTH));
  assign stab_bad  = stalled_q && (!out_valid || (out_data != hold_data));
  assign stall_bad = stall && (stall_nxt == SW'(STALL_MAX));

  generate
    if (CHECK_DATA != 0) begin : g_data
      logic [DEPTH-1:0][WIDTH-1:0] mem;
      always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_data;
      end
      assign data_bad = rd_en && (out_data != mem[rd_ptr]);
    end else begin : g_nodata
      assign data_bad = 1'b0;
    end
  endgenerate

  assign det = {ovf_bad, unf_bad, cnt_bad, data_bad, stab_bad, stall_bad};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ       <= '0;
      max_occ   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      stall_cnt <= '0;
      stalled_q <= 1'b0;
      hold_data <= '0;
      err_q     <= '0;
    end else begin
      occ       <= occ_nxt;
      max_occ   <= max_nxt;
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      stall_cnt <= stall_nxt;
      stalled_q <= stall;
      if (stall) hold_data <= out_data;
      // New detections win over a same-cycle clear.
      err_q     <= (err_q & {6{~clear}}) | det;
    end
  end

  assign {err_overflow, err_underflow, err_count,
          err_data, err_stability, err_stall} = err_q;
  assign err_any = |err_q;
endmodule

// File: tb/tb_fifo_protocol_monitor.sv
// Table-driven bench: two monitors (FULL_BYPASS 0/1) share stimulus; expected
// records are queued when driven and compared after the clock edge.
module tb_fifo_protocol_monitor;
  typedef struct {
    logic       iv, ir;
    logic [7:0] id;
    logic       ov, rdy;
    logic [7:0] od;
    logic [2:0] cnt;
    logic       clr, rst;
    logic [2:0] e_occ, e_max;
    logic [5:0] e_err, e_berr;
  } vec_t;

  localparam logic [5:0] OVF = 6'b100000, UNF = 6'b010000, CNT = 6'b001000,
                         DAT = 6'b000100, STB = 6'b000010, STL = 6'b000001;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 0, in_ready = 0, out_valid = 0, out_ready = 0, clear = 0;
  logic [7:0] in_data = 0, out_data = 0;
  logic [2:0] count = 0;
  logic       a_ovf, a_unf, a_cnt, a_dat, a_stb, a_stl, a_any;
  logic       b_ovf, b_unf, b_cnt, b_dat, b_stb, b_stl, b_any;
  logic [2:0] a_occ, a_max, b_occ, b_max;

  int errors = 0, checks = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  fifo_protocol_monitor #(.DEPTH(4), .WIDTH(8), .STALL_MAX(8), .CHECK_DATA(1), .FULL_BYPASS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count), .clear(clear),
    .err_overflow(a_ovf), .err_underflow(a_unf), .err_count(a_cnt), .err_data(a_dat),
    .err_stability(a_stb), .err_stall(a_stl), .err_any(a_any), .occ(a_occ), .max_occ(a_max));

  fifo_protocol_monitor #(.DEPTH(4), .WIDTH(8), .STALL_MAX(8), .CHECK_DATA(1), .FULL_BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count), .clear(clear),
    .err_overflow(b_ovf), .err_underflow(b_unf), .err_count(b_cnt), .err_data(b_dat),
    .err_stability(b_stb), .err_stall(b_stl), .err_any(b_any), .occ(b_occ), .max_occ(b_max));

  function automatic vec_t mk(input logic iv, ir, input logic [7:0] id, input logic ov, rdy,
                              input logic [7:0] od, input logic [2:0] cnt, input logic clr, rst,
                              input logic [2:0] eo, em, input logic [5:0] ee, eb);
    vec_t v;
    v.iv = iv; v.ir = ir; v.id = id; v.ov = ov; v.rdy = rdy; v.od = od; v.cnt = cnt;
    v.clr = clr; v.rst = rst; v.e_occ = eo; v.e_max = em; v.e_err = ee; v.e_berr = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    rst_n = ~v.rst; clear = v.clr; count = v.cnt;
    in_valid = v.iv; in_ready = v.ir; in_data = v.id;
    out_valid = v.ov; out_ready = v.rdy; out_data = v.od;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("occ", idx, a_occ, e.e_occ);
    chk("max_occ", idx, a_max, e.e_max);
    chk("err", idx, {a_ovf, a_unf, a_cnt, a_dat, a_stb, a_stl}, e.e_err);
    chk("err_any", idx, a_any, |e.e_err);
    chk("byp_err", idx, {b_ovf, b_unf, b_cnt, b_dat, b_stb, b_stl}, e.e_berr);
    chk("byp_occ", idx, b_occ, e.e_occ);
  endtask

  initial begin
    // reset, then fill/drain with matching data
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 0,1, 0,0, 0,0));
    tbl.push_back(mk(1,1,8'h11, 0,0,8'h00, 0, 0,0, 1,1, 0,0));
    tbl.push_back(mk(1,1,8'h22, 0,0,8'h00, 1, 0,0, 2,2, 0,0));
    tbl.push_back(mk(1,1,8'h33, 0,0,8'h00, 2, 0,0, 3,3, 0,0));
    tbl.push_back(mk(1,1,8'h44, 0,0,8'h00, 3, 0,0, 4,4, 0,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h11, 4, 0,0, 3,4, 0,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h22, 3, 0,0, 2,4, 0,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h33, 2, 0,0, 1,4, 0,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h44, 1, 0,0, 0,4, 0,0));
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 0,0, 0,4, 0,0));
    // ordering error, then clear
    tbl.push_back(mk(1,1,8'hA5, 0,0,8'h00, 0, 0,0, 1,4, 0,0));
    tbl.push_back(mk(1,1,8'h5A, 0,0,8'h00, 1, 0,0, 2,4, 0,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h5A, 2, 0,0, 1,4, DAT,DAT));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'hA5, 1, 0,0, 0,4, DAT,DAT));
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 1,0, 0,0, 0,0));
    // fill, overflow without pop, bypass push+pop at full, drain
    tbl.push_back(mk(1,1,8'h01, 0,0,8'h00, 0, 0,0, 1,1, 0,0));
    tbl.push_back(mk(1,1,8'h02, 0,0,8'h00, 1, 0,0, 2,2, 0,0));
    tbl.push_back(mk(1,1,8'h03, 0,0,8'h00, 2, 0,0, 3,3, 0,0));
    tbl.push_back(mk(1,1,8'h04, 0,0,8'h00, 3, 0,0, 4,4, 0,0));
    tbl.push_back(mk(1,1,8'h05, 0,0,8'h00, 4, 0,0, 4,4, OVF,OVF));
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 4, 1,0, 4,4, 0,0));
    tbl.push_back(mk(1,1,8'h05, 1,1,8'h01, 4, 0,0, 4,4, OVF,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h02, 4, 0,0, 3,4, OVF,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h03, 3, 0,0, 2,4, OVF,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h04, 2, 0,0, 1,4, OVF,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h05, 1, 0,0, 0,4, OVF,0));
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 1,0, 0,0, 0,0));
    // underflow and count mismatch at empty
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h00, 0, 0,0, 0,0, UNF,UNF));
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,0, UNF|CNT,UNF|CNT));
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 1,0, 0,0, 0,0));
    // stall timeout: 8 stable stall cycles
    tbl.push_back(mk(1,1,8'h77, 0,0,8'h00, 0, 0,0, 1,1, 0,0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(0,0,8'h00, 1,0,8'h77, 1, 0,0, 1,1, 0,0));
    tbl.push_back(mk(0,0,8'h00, 1,0,8'h77, 1, 0,0, 1,1, STL,STL));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h77, 1, 0,0, 0,1, STL,STL));
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 1,0, 0,0, 0,0));
    // data changes in the third stall cycle
    tbl.push_back(mk(1,1,8'h88, 0,0,8'h00, 0, 0,0, 1,1, 0,0));
    tbl.push_back(mk(0,0,8'h00, 1,0,8'h88, 1, 0,0, 1,1, 0,0));
    tbl.push_back(mk(0,0,8'h00, 1,0,8'h88, 1, 0,0, 1,1, 0,0));
    tbl.push_back(mk(0,0,8'h00, 1,0,8'h99, 1, 0,0, 1,1, STB,STB));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h88, 1, 0,0, 0,1, STB,STB));
    tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0, 1,0, 0,0, 0,0));
    // reset mid-fill, then a clean push/pop
    tbl.push_back(mk(1,1,8'h01, 0,0,8'h00, 0, 0,0, 1,1, 0,0));
    tbl.push_back(mk(1,1,8'h02, 0,0,8'h00, 1, 0,0, 2,2, 0,0));
    tbl.push_back(mk(1,1,8'h03, 0,0,8'h00, 2, 0,0, 3,3, 0,0));
    tbl.push_back(mk(1,1,8'h04, 0,0,8'h00, 3, 0,1, 0,0, 0,0));
    tbl.push_back(mk(1,1,8'h10, 0,0,8'h00, 0, 0,0, 1,1, 0,0));
    tbl.push_back(mk(0,0,8'h00, 1,1,8'h10, 1, 0,0, 0,1, 0,0));

    foreach (tbl[i]) apply(tbl[i], i);

    // a violation arriving with clear keeps its flag
    rst_n = 1; clear = 1; count = 3'd1;
    in_valid = 0; in_ready = 0; out_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    chk("set_wins_clear", 100, a_cnt, 1);
    chk("set_wins_any", 100, a_any, 1);
    chk("set_wins_max", 100, a_max, 0);
    clear = 1; count = 3'd0;
    @(posedge clk); #1;
    chk("clear_after", 101, {a_ovf, a_unf, a_cnt, a_dat, a_stb, a_stl}, 0);
    chk("clear_after_any", 101, a_any, 0);
    clear = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
